// File: rtl/sram_pkg.sv
// Shared definitions for the 32-bit-over-16-bit SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts SRAM cycles inside a LOW or HIGH phase.
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last,
    output logic pre_last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // pre_last lets the owner register an output that must change on the last cycle
    assign last     = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
    assign pre_last = (cnt_q == CNT_W'(WAIT_CYCLES - 2));

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two 16-bit SRAM phases (low half, then high half).
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    state_e      state_q;
    logic        wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [17:0] addr_q;
    logic [15:0] dq_out_q;
    logic        dq_oe_q;
    logic        we_n_q;

    logic        req;
    logic        in_phase;
    logic        ph_last;
    logic        ph_pre_last;
    logic [31:0] offs;
    logic [16:0] word_d;
    logic        unused_offs;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign in_phase = (state_q == S_LOW) || (state_q == S_HIGH);
    assign offs     = address - BASE_ADDR;
    // Word index bits above 16 do not fit the 18-bit halfword bus and are dropped
    assign word_d      = offs[18:2];
    assign unused_offs = ^{offs[31:19], offs[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_phase || ph_last),
        .enable  (in_phase && !ph_last),
        .last    (ph_last),
        .pre_last(ph_pre_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q  <= S_LOW;
                        wr_q     <= MEM_W_EN;
                        word_q   <= word_d;
                        wdata_q  <= wdata;
                        addr_q   <= {word_d, 1'b0};
                        dq_out_q <= wdata[15:0];
                        dq_oe_q  <= MEM_W_EN;
                        we_n_q   <= ~MEM_W_EN;
                    end
                end
                S_LOW: begin
                    if (ph_last) begin
                        state_q  <= S_HIGH;
                        addr_q   <= {word_q, 1'b1};
                        dq_out_q <= wdata_q[31:16];
                        we_n_q   <= ~wr_q;
                        if (!wr_q) rdata_q[15:0] <= sram_dq_in;
                    end else if (ph_pre_last) begin
                        // strobe released one cycle early so data is held past it
                        we_n_q <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (ph_last) begin
                        state_q <= S_DONE;
                        dq_oe_q <= 1'b0;
                        we_n_q  <= 1'b1;
                        if (!wr_q) rdata_q[31:16] <= sram_dq_in;
                    end else if (ph_pre_last) begin
                        we_n_q <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready       = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (2 and 4 wait cycles) against a cycle-index model.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        r_en[2], w_en[2];
    logic [31:0] a_in[2], wd_in[2], rd_o[2];
    logic        rdy_o[2], oe_o[2], we_o[2];
    logic [17:0] sa_o[2];
    logic [15:0] dqi[2], dqo_o[2];

    // Read-only SRAM image: halfwords 0/1 hold 0xBEEF/0xDEAD, the rest a hash
    function automatic logic [15:0] rom(input logic [17:0] a);
        if (a == 18'd0) return 16'hBEEF;
        if (a == 18'd1) return 16'hDEAD;
        return (a[15:0] * 16'h9E37) ^ {a[17:16], 14'h2C5A};
    endfunction

    assign dqi[0] = rom(sa_o[0]);
    assign dqi[1] = rom(sa_o[1]);

    sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
        .address(a_in[0]), .wdata(wd_in[0]), .rdata(rd_o[0]), .ready(rdy_o[0]),
        .sram_addr(sa_o[0]), .sram_dq_in(dqi[0]), .sram_dq_out(dqo_o[0]),
        .sram_dq_oe(oe_o[0]), .sram_we_n(we_o[0])
    );

    sram_controller #(.WAIT_CYCLES(4), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
        .address(a_in[1]), .wdata(wd_in[1]), .rdata(rd_o[1]), .ready(rdy_o[1]),
        .sram_addr(sa_o[1]), .sram_dq_in(dqi[1]), .sram_dq_out(dqo_o[1]),
        .sram_dq_oe(oe_o[1]), .sram_we_n(we_o[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    // Model: m_k = cycles since the request cycle (request cycle is 0)
    bit          m_busy[2];
    int          m_k[2];
    bit          m_wr[2];
    logic [16:0] m_word[2];
    logic [31:0] m_wd[2];
    logic [17:0] m_addr[2];
    logic [31:0] m_rd[2];
    bit          x_rdy[2];

    logic        s_rdy[2], s_we[2], s_oe[2];
    logic [17:0] s_addr[2];
    logic [15:0] s_dq[2];
    logic [31:0] s_rd[2];

    logic        t_rdy[10], t_we[10], t_oe[10];
    logic [17:0] t_addr[10];
    logic [15:0] t_dq[10];
    logic [31:0] t_rd[10];

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, want %h", name, i, act, exp);
        end
    endtask

    task automatic cycle();
        logic        e_we[2], e_oe[2], e_rdy[2];
        logic [17:0] e_addr[2];
        logic [15:0] e_dq[2];
        for (int i = 0; i < 2; i++) begin
            int W, k, pos;
            bit hi;
            W = wc(i);
            k = m_k[i];
            if (rst) begin
                m_busy[i] = 1'b0; m_addr[i] = '0; m_rd[i] = '0;
            end
            e_we[i] = 1'b1; e_oe[i] = 1'b0; e_addr[i] = m_addr[i]; e_dq[i] = '0; e_rdy[i] = 1'b0;
            if (!m_busy[i]) begin
                e_rdy[i] = !(r_en[i] || w_en[i]);
            end else if (k == 2 * W + 1) begin
                e_rdy[i] = 1'b1;
            end else begin
                hi        = (k > W);
                pos       = hi ? k - W : k;
                e_addr[i] = {m_word[i], hi};
                e_oe[i]   = m_wr[i];
                e_we[i]   = !(m_wr[i] && pos != W);
                e_dq[i]   = hi ? m_wd[i][31:16] : m_wd[i][15:0];
            end
            x_rdy[i] = e_rdy[i];
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_rdy[i] = rdy_o[i]; s_we[i] = we_o[i]; s_oe[i] = oe_o[i];
            s_addr[i] = sa_o[i]; s_dq[i] = dqo_o[i]; s_rd[i] = rd_o[i];
            chk("ready", i, rdy_o[i], e_rdy[i]);
            chk("we_n", i, we_o[i], e_we[i]);
            chk("dq_oe", i, oe_o[i], e_oe[i]);
            chk("sram_addr", i, sa_o[i], e_addr[i]);
            chk("rdata", i, rd_o[i], m_rd[i]);
            if (e_oe[i]) chk("dq_out", i, dqo_o[i], e_dq[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int W, pos;
            bit hi;
            W = wc(i);
            if (rst) begin
                m_busy[i] = 1'b0; m_addr[i] = '0; m_rd[i] = '0;
            end else if (!m_busy[i]) begin
                if (r_en[i] || w_en[i]) begin
                    m_busy[i] = 1'b1;
                    m_k[i]    = 1;
                    m_wr[i]   = w_en[i];
                    m_word[i] = 17'((a_in[i] - BASE) >> 2);
                    m_wd[i]   = wd_in[i];
                end
            end else if (m_k[i] == 2 * W + 1) begin
                m_busy[i] = 1'b0;
            end else begin
                hi        = (m_k[i] > W);
                pos       = hi ? m_k[i] - W : m_k[i];
                m_addr[i] = {m_word[i], hi};
                if (!m_wr[i] && pos == W) begin
                    if (hi) m_rd[i][31:16] = rom({m_word[i], hi});
                    else    m_rd[i][15:0]  = rom({m_word[i], hi});
                end
                m_k[i]++;
            end
        end
        #1;
    endtask

    // Holds the request through DONE like a frozen pipeline, recording each cycle
    task automatic run_access(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        r_en[i] = r; w_en[i] = w; a_in[i] = a; wd_in[i] = d;
        for (int c = 0; c <= 2 * wc(i) + 1; c++) begin
            cycle();
            t_rdy[c] = s_rdy[i]; t_we[c] = s_we[i]; t_oe[c] = s_oe[i];
            t_addr[c] = s_addr[i]; t_dq[c] = s_dq[i]; t_rd[c] = s_rd[i];
        end
        r_en[i] = 1'b0; w_en[i] = 1'b0;
    endtask

    task automatic new_req(input int i);
        int sel;
        sel = $urandom_range(9);
        r_en[i]  = (sel >= 3 && sel <= 5) || sel == 9;
        w_en[i]  = (sel >= 6);
        a_in[i]  = ($urandom_range(3) == 0) ? $urandom() : BASE + $urandom_range(255);
        wd_in[i] = $urandom();
    endtask

    logic [17:0] lw_addr[4];
    logic [15:0] lw_dq[4];
    logic        lw_we[4];
    int          low_cnt;
    int          we_cnt;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 1'b0; w_en[i] = 1'b0; a_in[i] = '0; wd_in[i] = '0;
            m_busy[i] = 1'b0; m_k[i] = 0; m_wr[i] = 1'b0; m_word[i] = '0;
            m_wd[i] = '0; m_addr[i] = '0; m_rd[i] = '0; x_rdy[i] = 1'b1;
        end
        cycle();
        chk("rst_ready", 0, s_rdy[0], 1'b1);
        chk("rst_we_n", 0, s_we[0], 1'b1);
        chk("rst_oe", 0, s_oe[0], 1'b0);
        chk("rst_addr", 0, s_addr[0], 18'd0);
        chk("rst_rdata", 1, s_rd[1], 32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // Write 0xDEADBEEF at 1024
        run_access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        lw_addr = '{18'd0, 18'd0, 18'd1, 18'd1};
        lw_dq   = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
        lw_we   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 1; c <= 4; c++) begin
            chk("w_addr", c, t_addr[c], lw_addr[c-1]);
            chk("w_dq", c, t_dq[c], lw_dq[c-1]);
            chk("w_we_n", c, t_we[c], lw_we[c-1]);
        end
        for (int c = 0; c <= 5; c++) chk("w_ready", c, t_rdy[c], (c == 5) ? 1'b1 : 1'b0);

        // Read at 1024 from the 0xBEEF/0xDEAD image
        run_access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        for (int c = 0; c <= 4; c++) chk("r_ready_lo", c, t_rdy[c], 1'b0);
        chk("r_ready_hi", 5, t_rdy[5], 1'b1);
        chk("r_rdata", 5, t_rd[5], 32'hDEADBEEF);

        // Both enables: a write to halfwords 4/5, rdata untouched
        run_access(0, 1'b1, 1'b1, 32'd1032, 32'h12345678);
        chk("rw_addr_lo", 1, t_addr[1], 18'd4);
        chk("rw_addr_hi", 3, t_addr[3], 18'd5);
        chk("rw_oe", 1, t_oe[1], 1'b1);
        chk("rw_we_n", 1, t_we[1], 1'b0);
        chk("rw_dq", 3, t_dq[3], 16'h1234);
        chk("rw_rdata", 5, t_rd[5], 32'hDEADBEEF);

        // Reset pulsed in the HIGH phase of a write
        r_en[0] = 1'b0; w_en[0] = 1'b1; a_in[0] = 32'd1088; wd_in[0] = $urandom();
        repeat (3) cycle();
        w_en[0] = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rstmid_we_n", 0, s_we[0], 1'b1);
        chk("rstmid_oe", 0, s_oe[0], 1'b0);
        chk("rstmid_rdata", 0, s_rd[0], 32'd0);
        chk("rstmid_ready", 0, s_rdy[0], 1'b1);
        rst = 1'b0;
        repeat (2) cycle();

        // Back-to-back read then write, write held through DONE
        low_cnt = 0;
        we_cnt  = 0;
        run_access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        for (int c = 0; c <= 5; c++) low_cnt += (t_rdy[c] == 1'b0) ? 1 : 0;
        run_access(0, 1'b0, 1'b1, 32'd1036, 32'hA5A5_5A5A);
        for (int c = 0; c <= 5; c++) begin
            low_cnt += (t_rdy[c] == 1'b0) ? 1 : 0;
            we_cnt  += (t_we[c] == 1'b0) ? 1 : 0;
        end
        cycle();
        chk("b2b_low_cycles", 0, low_cnt, 10);
        chk("b2b_strobes", 0, we_cnt, 2);
        chk("b2b_idle_ready", 0, s_rdy[0], 1'b1);

        // Four wait cycles: high word bits discarded, ready at cycle 9
        run_access(1, 1'b1, 1'b0, 32'h0004_0400, 32'h0);
        chk("w4_addr_lo", 1, t_addr[1], 18'h20000);
        chk("w4_addr_hi", 5, t_addr[5], 18'h20001);
        chk("w4_ready8", 8, t_rdy[8], 1'b0);
        chk("w4_ready9", 9, t_rdy[9], 1'b1);
        chk("w4_rdata", 9, t_rd[9], {rom(18'h20001), rom(18'h20000)});
        run_access(1, 1'b1, 1'b0, 32'h0008_0400, 32'h0);
        chk("w4_wrap_addr", 1, t_addr[1], 18'd0);
        chk("w4_wrap_rdata", 9, t_rd[9], 32'hDEADBEEF);

        // Randomized traffic on both instances
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(r_en[i] || w_en[i]) || x_rdy[i] || $urandom_range(15) == 0) new_req(i);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
